block_fill_demux8: RTL and testbench
====================================

// Module: block_fill_demux8
// PURPOSE
//  Write-side counterpart of the 8-way 256-bit block read mux in the 4-way set-associative cache.
//  Accepts a fill request naming a destination slot (0..7), then collects eight 32-bit memory beats.
//  Assembles the beats into one 256-bit block and writes it to the selected slot.
//  The write is a single-cycle one-hot write-enable plus a shared 256-bit data bus.
//  Sits between the memory refill path and the cache block storage.
// PARAMETERS
//  BLOCK_W  256  block width in bits
//  WORD_W   32   beat width in bits; BLOCK_W/WORD_W = 8 beats per block
//  NUM_OUT  8    number of destination slots
//  SEL_W    3    slot index width, clog2(NUM_OUT)
// PORTS
//  clk         in   1        single clock, all logic rising-edge
//  reset       in   1        asynchronous, active-high reset
//  req_valid   in   1        fill request valid
//  req_ready   out  1        fill request accepted when req_valid && req_ready
//  req_sel     in   SEL_W    destination slot of the request
//  beat_valid  in   1        memory beat valid
//  beat_ready  out  1        beat consumed when beat_valid && beat_ready
//  beat_data   in   WORD_W   memory beat payload
//  blk_we      out  NUM_OUT  one-hot write enable, bit i writes slot i
//  blk_data    out  BLOCK_W  assembled block; valid while any blk_we bit is high
//  busy        out  1        high in FILL or WRITE state
//  done        out  1        one-cycle pulse, coincident with blk_we
// BEHAVIOUR
//  Reset: state=IDLE; req_ready=1; beat_ready=0; blk_we=0; blk_data=0; busy=0; done=0; beat count=0.
//  All outputs are registered, except req_ready and beat_ready, which are decoded from state.
//  IDLE:
//   - req_ready=1, beat_ready=0.
//   - On an accepted request: latch req_sel, clear the beat counter, go to FILL.
//  FILL:
//   - beat_ready=1, req_ready=0.
//   - Each accepted beat is written to bits [pos*WORD_W +: WORD_W], where pos is the 3-bit beat position.
//   - The position increments by 1 modulo 8 on each accepted beat.
//   - Stalls (beat_valid=0) hold all state; there is no timeout.
//   - When the 8th beat is accepted, go to WRITE.
//  WRITE (exactly one cycle):
//   - blk_we = 1<<sel_q; blk_data = assembled block; done=1.
//   - Next state is IDLE.
//   - Assembly register contents are held until the next fill overwrites them.
//  Latency: request accepted in cycle 0; beats accepted no earlier than cycles 1..8.
//   With back-to-back beats, blk_we/done are high in cycle 9; the next request is accepted no earlier than cycle 10.
//  A request presented in FILL or WRITE is not accepted (req_ready=0); the requester must hold it stable.
//  A beat presented in IDLE or WRITE is not consumed (beat_ready=0).
//  Reset asserted mid-fill:
//   - Immediately returns to IDLE with blk_we=0.
//   - A partial block is never written; collected beats are discarded.
//  blk_we never has more than one bit set; it is all-zero outside WRITE.
// CONFIGURATION
//  BLOCK_FILL_CRIT_FIRST_EN defined:
//   - Adds input port req_word [2:0], latched with the request.
//   - The first beat is placed at position req_word; later beats wrap 7->0 (critical-word-first refill).
//   - FILL still ends after exactly 8 beats.
//  BLOCK_FILL_CRIT_FIRST_EN undefined:
//   - Port req_word is absent; the first beat always goes to position 0.
// STRUCTURE
//  Package cache_blk_pkg holds:
//   - constants BLOCK_W, WORD_W, WORDS_PER_BLK=8, NUM_OUT, SEL_W;
//   - the fill FSM state encoding (IDLE, FILL, WRITE).
//  Sub-module: decoder3to8. It maps sel_q to the one-hot vector that gates blk_we in WRITE.
// TESTING
//  1. Reset, req_sel=5, beats 0x0..0x7 back-to-back
//     -> cycle 9: blk_we=8'b0010_0000, blk_data[31:0]=0x0, blk_data[255:224]=0x7, done=1.
//  2. req_sel=0, beats 0xA0..0xA7 with beat_valid low every other cycle
//     -> no early write; blk_we=8'h01 one cycle after the 8th beat.
//  3. Reset asserted after the 4th beat, then req_sel=2 with beats 0xB0..0xB7
//     -> no write before the new fill; after it, blk_we=8'h04 and the block holds only 0xB* words.
//  4. req_valid held high with req_sel=7 throughout a fill
//     -> req_ready=0 until IDLE; a second fill to slot 7 starts the cycle after done.
//  5. With BLOCK_FILL_CRIT_FIRST_EN: req_word=6, beats 0x60..0x67
//     -> blk_data[223:192]=0x60, [255:224]=0x61, [31:0]=0x62, [191:160]=0x67.
//  6. beat_valid pulsed while IDLE with no request
//     -> beat_ready=0, blk_we stays 0, busy=0.

Source files
------------

// File: rtl/cache_blk_pkg.sv
// Shared constants and fill FSM encoding for the cache block refill path.
package cache_blk_pkg;

  localparam int unsigned BLOCK_W       = 256;
  localparam int unsigned WORD_W        = 32;
  localparam int unsigned WORDS_PER_BLK = BLOCK_W / WORD_W;
  localparam int unsigned NUM_OUT       = 8;
  localparam int unsigned SEL_W         = 3;
  localparam int unsigned POS_W         = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_WRITE = 2'd2
  } fill_state_e;

endpackage

// File: rtl/decoder3to8.sv
// Binary slot index to one-hot slot vector.
module decoder3to8
  import cache_blk_pkg::*;
(
  input  logic [SEL_W-1:0]   i_sel,
  output logic [NUM_OUT-1:0] o_onehot_c
);

  // Exactly one bit set for any index.
  always_comb begin
    o_onehot_c        = '0;
    o_onehot_c[i_sel] = 1'b1;
  end

endmodule

// File: rtl/block_fill_demux8.sv
// Collects eight 32-bit refill beats into a 256-bit block and writes it to
// one of eight slots with a single-cycle one-hot write enable.
// Optional: BLOCK_FILL_CRIT_FIRST_EN adds req_word so the first beat lands at
// a chosen word position (critical-word-first refill).
module block_fill_demux8
  import cache_blk_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [SEL_W-1:0]   req_sel,
`ifdef BLOCK_FILL_CRIT_FIRST_EN
  input  logic [POS_W-1:0]   req_word,
`endif
  input  logic               beat_valid,
  output logic               beat_ready,
  input  logic [WORD_W-1:0]  beat_data,
  output logic [NUM_OUT-1:0] blk_we,
  output logic [BLOCK_W-1:0] blk_data,
  output logic               busy,
  output logic               done
);

  fill_state_e          r_state;
  fill_state_e          w_next_state;
  logic [SEL_W-1:0]     r_sel;
  logic [POS_W-1:0]     r_cnt;
  logic [POS_W-1:0]     w_pos;
  logic [BLOCK_W-1:0]   r_blk;
  logic [NUM_OUT-1:0]   w_onehot;
  logic                 w_req_fire;
  logic                 w_beat_fire;

`ifdef BLOCK_FILL_CRIT_FIRST_EN
  logic [POS_W-1:0]     r_pos;
  assign w_pos = r_pos;
`else
  assign w_pos = r_cnt;
`endif

  decoder3to8 u_dec (
    .i_sel      (r_sel),
    .o_onehot_c (w_onehot)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state and handshake decode.
  always_comb begin
    w_next_state = r_state;
    req_ready    = 1'b0;
    beat_ready   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_next_state = ST_FILL;
      end
      ST_FILL: begin
        beat_ready = 1'b1;
        if (beat_valid && (r_cnt == POS_W'(WORDS_PER_BLK - 1))) w_next_state = ST_WRITE;
      end
      ST_WRITE: w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
    w_req_fire  = req_valid && req_ready;
    w_beat_fire = beat_valid && beat_ready;
  end

  // Request latch, beat assembly and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sel  <= '0;
      r_cnt  <= '0;
      r_blk  <= '0;
      blk_we <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
`ifdef BLOCK_FILL_CRIT_FIRST_EN
      r_pos  <= '0;
`endif
    end else begin
      if (w_req_fire) begin
        r_sel <= req_sel;
        r_cnt <= '0;
`ifdef BLOCK_FILL_CRIT_FIRST_EN
        r_pos <= req_word;
`endif
      end
      if (w_beat_fire) begin
        r_blk[int'(w_pos) * WORD_W +: WORD_W] <= beat_data;
        r_cnt <= r_cnt + POS_W'(1);
`ifdef BLOCK_FILL_CRIT_FIRST_EN
        r_pos <= r_pos + POS_W'(1);
`endif
      end
      blk_we <= (w_next_state == ST_WRITE) ? w_onehot : '0;
      done   <= (w_next_state == ST_WRITE);
      busy   <= (w_next_state != ST_IDLE);
    end
  end

  // Assembly register drives the shared data bus; it holds until the next fill.
  assign blk_data = r_blk;

endmodule

// File: tb/tb_block_fill_demux8.sv
// Scoreboard bench for block_fill_demux8: fills push expected writes,
// a negedge monitor pops and compares whenever blk_we is asserted.
module tb_block_fill_demux8;

  logic         clk = 1'b0;
  logic         reset;
  logic         req_valid;
  logic         req_ready;
  logic [2:0]   req_sel;
`ifdef BLOCK_FILL_CRIT_FIRST_EN
  logic [2:0]   req_word;
`endif
  logic         beat_valid;
  logic         beat_ready;
  logic [31:0]  beat_data;
  logic [7:0]   blk_we;
  logic [255:0] blk_data;
  logic         busy;
  logic         done;

  typedef struct {
    logic [7:0]   we;
    logic [255:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  block_fill_demux8 dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_sel    (req_sel),
`ifdef BLOCK_FILL_CRIT_FIRST_EN
    .req_word   (req_word),
`endif
    .beat_valid (beat_valid),
    .beat_ready (beat_ready),
    .beat_data  (beat_data),
    .blk_we     (blk_we),
    .blk_data   (blk_data),
    .busy       (busy),
    .done       (done)
  );

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected block: beat k lands at word (word + k) mod 8.
  task automatic push_exp(input logic [2:0] sel, input logic [2:0] word, input logic [31:0] base);
    exp_t e;
    logic [2:0] p;
    e.we   = 8'h01 << sel;
    e.data = '0;
    for (int k = 0; k < 8; k++) begin
      p = word + 3'(k);
      e.data[p*32 +: 32] = base + 32'(k);
    end
    exp_q.push_back(e);
  endtask

  // Present a request until accepted; returns just after the accepting edge.
  task automatic send_req(input logic [2:0] sel, input logic [2:0] word, input bit hold);
    bit acc;
    req_valid = 1'b1;
    req_sel   = sel;
`ifdef BLOCK_FILL_CRIT_FIRST_EN
    req_word  = word;
`else
    if (word != 3'd0) $display("note: req_word ignored in this build");
`endif
    acc = 1'b0;
    for (int t = 0; t < 40 && !acc; t++) begin
      @(negedge clk); acc = req_ready;
      @(posedge clk); #1;
    end
    if (!acc) begin
      n_cmp++; n_err++;
      $display("FAIL req_accept_timeout: got not accepted expected accepted");
    end
    if (!hold) req_valid = 1'b0;
  endtask

  // Send n beats base, base+1, ... with gap idle cycles between beats.
  task automatic send_beats(input logic [31:0] base, input int n, input int gap);
    bit acc;
    for (int k = 0; k < n; k++) begin
      beat_valid = 1'b1;
      beat_data  = base + 32'(k);
      acc = 1'b0;
      for (int t = 0; t < 40 && !acc; t++) begin
        @(negedge clk); acc = beat_ready;
        @(posedge clk); #1;
      end
      if (!acc) begin
        n_cmp++; n_err++;
        $display("FAIL beat_accept_timeout: got not accepted expected accepted");
      end
      beat_valid = 1'b0;
      if (k != n - 1) repeat (gap) begin @(posedge clk); #1; end
    end
  endtask

  // Monitor: every write must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset === 1'b0 && blk_we !== 8'h00) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_write: got we=%b expected none", blk_we);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_we",   256'(blk_we), 256'(e.we));
        check("sb_data", blk_data,     e.data);
        check("sb_done", 256'(done),   256'(1'b1));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_sel = '0; beat_valid = 1'b0; beat_data = '0;
`ifdef BLOCK_FILL_CRIT_FIRST_EN
    req_word = '0;
`endif
    repeat (2) @(negedge clk);
    check("rst_req_ready",  256'(req_ready),  256'(1'b1));
    check("rst_beat_ready", 256'(beat_ready), 256'(1'b0));
    check("rst_blk_we",     256'(blk_we),     256'(8'h00));
    check("rst_blk_data",   blk_data,         256'(0));
    check("rst_busy",       256'(busy),       256'(1'b0));
    check("rst_done",       256'(done),       256'(1'b0));
    @(posedge clk); #1; reset = 1'b0;
    @(posedge clk); #1;

    // 1: slot 5, back-to-back beats 0..7; write visible in cycle 9.
    push_exp(3'd5, 3'd0, 32'h0);
    send_req(3'd5, 3'd0, 1'b0);
    check("t1_busy_fill", 256'(busy), 256'(1'b1));
    send_beats(32'h0, 8, 0);
    check("t1_we",       256'(blk_we),          256'(8'b0010_0000));
    check("t1_word0",    256'(blk_data[31:0]),  256'(32'h0));
    check("t1_word7",    256'(blk_data[255:224]), 256'(32'h7));
    check("t1_done",     256'(done),            256'(1'b1));
    @(posedge clk); #1;
    check("t1_we_clear", 256'(blk_we),          256'(8'h00));
    check("t1_idle",     256'(busy),            256'(1'b0));

    // 2: slot 0 with a stall between every beat.
    push_exp(3'd0, 3'd0, 32'hA0);
    send_req(3'd0, 3'd0, 1'b0);
    send_beats(32'hA0, 7, 1);
    check("t2_no_early_we", 256'(blk_we), 256'(8'h00));
    @(posedge clk); #1;
    send_beats(32'hA7, 1, 0);
    check("t2_we", 256'(blk_we), 256'(8'h01));

    // 3: reset after four beats discards the partial block.
    @(posedge clk); #1;
    send_req(3'd6, 3'd0, 1'b0);
    send_beats(32'h90, 4, 0);
    reset = 1'b1; #1;
    check("t3_rst_we",    256'(blk_we),    256'(8'h00));
    check("t3_rst_busy",  256'(busy),      256'(1'b0));
    check("t3_rst_rdy",   256'(req_ready), 256'(1'b1));
    check("t3_rst_bready",256'(beat_ready),256'(1'b0));
    @(posedge clk); #1; reset = 1'b0;
    push_exp(3'd2, 3'd0, 32'hB0);
    send_req(3'd2, 3'd0, 1'b0);
    send_beats(32'hB0, 8, 0);
    check("t3_we", 256'(blk_we), 256'(8'h04));

    // 4: request held for slot 7 through a fill; reaccepted right after done.
    @(posedge clk); #1;
    push_exp(3'd7, 3'd0, 32'hC0);
    send_req(3'd7, 3'd0, 1'b1);
    check("t4_rdy_fill", 256'(req_ready), 256'(1'b0));
    send_beats(32'hC0, 8, 0);
    check("t4_rdy_write", 256'(req_ready), 256'(1'b0));
    check("t4_done",      256'(done),      256'(1'b1));
    push_exp(3'd7, 3'd0, 32'hD0);
    @(negedge clk);
    @(negedge clk);
    check("t4_rdy_idle",  256'(req_ready), 256'(1'b1));
    check("t4_busy_idle", 256'(busy),      256'(1'b0));
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("t4_busy_2nd",  256'(busy),      256'(1'b1));
    send_beats(32'hD0, 8, 0);
    check("t4_we_2nd",    256'(blk_we),    256'(8'h80));

`ifdef BLOCK_FILL_CRIT_FIRST_EN
    // 5: critical word first starting at word 6.
    @(posedge clk); #1;
    push_exp(3'd3, 3'd6, 32'h60);
    send_req(3'd3, 3'd6, 1'b0);
    send_beats(32'h60, 8, 0);
    check("t5_w6", 256'(blk_data[223:192]), 256'(32'h60));
    check("t5_w7", 256'(blk_data[255:224]), 256'(32'h61));
    check("t5_w0", 256'(blk_data[31:0]),    256'(32'h62));
    check("t5_w5", 256'(blk_data[191:160]), 256'(32'h67));
`endif

    // 6: beats offered in IDLE are ignored.
    @(posedge clk); #1;
    @(posedge clk); #1;
    beat_valid = 1'b1; beat_data = 32'hDEAD_BEEF; #1;
    check("t6_bready", 256'(beat_ready), 256'(1'b0));
    repeat (3) begin @(posedge clk); #1; end
    check("t6_we",   256'(blk_we), 256'(8'h00));
    check("t6_busy", 256'(busy),   256'(1'b0));
    beat_valid = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("sb_drained", 256'(exp_q.size()), 256'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
